// File: rtl/mpu6050_reg_writer.sv
// -----------------------------------------------------------------------------
// mpu6050_reg_writer
//   Single-register I2C write master for the MPU6050. Each accepted request
//   sends START, {DEV_ADDR,W}, register address, register value, STOP, and
//   checks the slave ACK after every byte. A NACK aborts straight to STOP.
//   Every bit slot is four SCL quarters of CLK_DIV clocks each.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   WrReq      write request, accepted when Busy is low
//   WrData     {register address[15:8], register value[7:0]}
//   WriteDone  one-clock pulse after STOP has completed
//   Busy       high from accept through the WriteDone cycle
//   AckErr     a NACK was seen in the last frame; cleared on accept
//   scl_oe     1 pulls SCL low, 0 releases it
//   sda_oe     1 pulls SDA low, 0 releases it
//   sda_i      synchronised SDA line level
// -----------------------------------------------------------------------------
module mpu6050_reg_writer #(
   parameter int unsigned CLK_DIV  = 125,
   parameter logic [6:0]  DEV_ADDR = 7'h68
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        WrReq,
   input  logic [15:0] WrData,
   output logic        WriteDone,
   output logic        Busy,
   output logic        AckErr,
   output logic        scl_oe,
   output logic        sda_oe,
   input  logic        sda_i
);

   localparam int unsigned   QW     = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [QW-1:0] Q_LAST = QW'(CLK_DIV - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_START, S_ADDR, S_ACK1, S_REG, S_ACK2, S_DATA, S_ACK3, S_STOP
   } state_t;

   state_t          state_q, state_d;
   logic [QW-1:0]   qcnt_q, qcnt_d;
   logic [1:0]      phase_q, phase_d;
   logic [2:0]      bitcnt_q, bitcnt_d;
   logic [15:0]     data_q, data_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            ackerr_q, ackerr_d;

   logic            q_wrap;
   logic            slot_end;
   logic            ack_sample;
   logic [7:0]      cur_byte;
   logic [2:0]      bit_idx;

   assign q_wrap     = (qcnt_q == Q_LAST);
   assign slot_end   = q_wrap && (phase_q == 2'd3);
   // ACK is taken on the last clock of q2, i.e. just before SCL is pulled low.
   assign ack_sample = q_wrap && (phase_q == 2'd2);
   assign bit_idx    = 3'd7 - bitcnt_q;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         qcnt_q   <= '0;
         phase_q  <= '0;
         bitcnt_q <= '0;
         data_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         ackerr_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         qcnt_q   <= qcnt_d;
         phase_q  <= phase_d;
         bitcnt_q <= bitcnt_d;
         data_q   <= data_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         ackerr_q <= ackerr_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d  = state_q;
      qcnt_d   = qcnt_q;
      phase_d  = phase_q;
      bitcnt_d = bitcnt_q;
      data_d   = data_q;
      busy_d   = busy_q;
      ackerr_d = ackerr_q;
      done_d   = 1'b0;

      // The FSM is already back in IDLE during the WriteDone cycle; Busy
      // stays high for that cycle and drops on the following edge.
      if (done_q) begin
         busy_d = 1'b0;
      end

      if (state_q != S_IDLE) begin
         if (q_wrap) begin
            qcnt_d  = '0;
            phase_d = phase_q + 2'd1;
         end else begin
            qcnt_d  = qcnt_q + 1'b1;
         end
      end

      unique case (state_q)
         S_IDLE: begin
            if (WrReq && !busy_q) begin
               state_d  = S_START;
               data_d   = WrData;
               ackerr_d = 1'b0;
               busy_d   = 1'b1;
               qcnt_d   = '0;
               phase_d  = '0;
               bitcnt_d = '0;
            end
         end
         S_START: begin
            if (slot_end) state_d = S_ADDR;
         end
         S_ADDR, S_REG, S_DATA: begin
            if (slot_end) begin
               bitcnt_d = bitcnt_q + 3'd1;
               if (bitcnt_q == 3'd7) begin
                  if (state_q == S_ADDR)     state_d = S_ACK1;
                  else if (state_q == S_REG) state_d = S_ACK2;
                  else                       state_d = S_ACK3;
               end
            end
         end
         S_ACK1, S_ACK2, S_ACK3: begin
            if (ack_sample && sda_i) ackerr_d = 1'b1;
            // ackerr_q already reflects this slot's sample by the slot end.
            if (slot_end) begin
               if (ackerr_q || (state_q == S_ACK3)) state_d = S_STOP;
               else if (state_q == S_ACK1)           state_d = S_REG;
               else                                  state_d = S_DATA;
            end
         end
         S_STOP: begin
            if (slot_end) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      scl_oe   = 1'b0;
      sda_oe   = 1'b0;
      cur_byte = '0;

      unique case (state_q)
         S_ADDR:  cur_byte = {DEV_ADDR, 1'b0};
         S_REG:   cur_byte = data_q[15:8];
         S_DATA:  cur_byte = data_q[7:0];
         default: cur_byte = '0;
      endcase

      unique case (state_q)
         S_START: begin
            sda_oe = phase_q[1];
            scl_oe = (phase_q == 2'd3);
         end
         S_ADDR, S_REG, S_DATA: begin
            sda_oe = ~cur_byte[bit_idx];
            scl_oe = (phase_q == 2'd0) || (phase_q == 2'd3);
         end
         S_ACK1, S_ACK2, S_ACK3: begin
            sda_oe = 1'b0;
            scl_oe = (phase_q == 2'd0) || (phase_q == 2'd3);
         end
         S_STOP: begin
            sda_oe = ~phase_q[1];
            scl_oe = (phase_q == 2'd0);
         end
         default: begin
            sda_oe = 1'b0;
            scl_oe = 1'b0;
         end
      endcase

      WriteDone = done_q;
      Busy      = busy_q;
      AckErr    = ackerr_q;
   end

endmodule

// File: doc/mpu6050_reg_writer.md
MPU6050_REG_WRITER -- requirements
Module: mpu6050_reg_writer

Interface
REQ-001 SHALL have parameter CLK_DIV, default 125, giving clk cycles per SCL quarter-period; legal range is 2 or more.
REQ-002 SHALL have parameter DEV_ADDR, default 7'h68, the 7-bit I2C slave address.
REQ-003 SHALL have port clk, input, 1 bit: system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port WrReq, input, 1 bit: request to write one register.
REQ-006 SHALL have port WrData, input, 16 bits: {register address[15:8], register value[7:0]}.
REQ-007 SHALL have port WriteDone, output, 1 bit: one-cycle pulse when the frame, including STOP, is complete.
REQ-008 SHALL have port Busy, output, 1 bit: high from request accept until the WriteDone cycle, inclusive.
REQ-009 SHALL have port AckErr, output, 1 bit: set when any of the three ACK slots is sampled high (NACK).
REQ-010 SHALL have port scl_oe, output, 1 bit: 1 pulls SCL low; 0 releases it.
REQ-011 SHALL have port sda_oe, output, 1 bit: 1 pulls SDA low; 0 releases it.
REQ-012 SHALL have port sda_i, input, 1 bit: sampled SDA line level, already synchronised externally.

Function
REQ-013 SHALL accept a request when WrReq=1 and Busy=0 at a clk edge.
- On accept, SHALL latch WrData, clear AckErr, and set Busy on the same edge.
- WrReq while Busy=1 SHALL be ignored; WrData is not re-sampled.
REQ-014 SHALL use a quarter counter that counts 0..CLK_DIV-1 and advances the phase q0..q3 on wrap; one bit slot is 4*CLK_DIV clks.
REQ-015 SHALL run the state machine IDLE -> START -> ADDR -> ACK1 -> REG -> ACK2 -> DATA -> ACK3 -> STOP -> IDLE.
- ADDR, REG and DATA are 8 bit slots each; ACKn, START and STOP are one slot each.
REQ-016 In a data bit slot, SHALL:
- drive SDA in q0 with SCL low;
- release SCL in q1 and q2;
- pull SCL low in q3.
- SDA SHALL NOT change while SCL is released.
REQ-017 SHALL send bytes MSB first: {DEV_ADDR,1'b0}, then WrData[15:8], then WrData[7:0].
REQ-018 START slot: SDA released and SCL released in q0-q1; SDA pulled low in q2 with SCL released; SCL pulled low in q3.
REQ-019 STOP slot: SDA pulled low and SCL low in q0; SCL released in q1; SDA released in q2-q3.
REQ-020 ACK slot: SHALL release SDA and sample sda_i on the last clk of q2.
- sda_i=1 SHALL set AckErr and go directly to STOP, skipping the remaining bytes.
REQ-021 SHALL pulse WriteDone for one clk at the end of STOP q3, drop Busy on the next edge, and return to IDLE.
- A full ACKed frame is 29 slots: WriteDone occurs exactly 116*CLK_DIV clks after the accept edge.
REQ-022 On a NACK abort, WriteDone SHALL still pulse, with AckErr=1 in that cycle.
- AckErr SHALL hold until the next accept.
REQ-023 In IDLE, SHALL hold scl_oe=0 and sda_oe=0, releasing the bus.
REQ-024 A WrReq asserted in the WriteDone cycle SHALL be ignored, because Busy=1 in that cycle; it is accepted on the next edge if still high.

Reset
REQ-025 While rst=0, SHALL force:
- state=IDLE, counters=0;
- WriteDone=0, Busy=0, AckErr=0, scl_oe=0, sda_oe=0;
- latched data = 16'h0000.
REQ-026 Reset asserted mid-frame SHALL release both lines immediately (asynchronously).
- No STOP is generated and no WriteDone is pulsed.

Verification
REQ-027 CLK_DIV=4, WrData=16'h6B00, slave ACKs all bytes -> bus carries 0xD0, 0x6B, 0x00 MSB first; WriteDone pulses once at accept+464 clks; AckErr=0.
REQ-028 WrData=16'h1AA5 -> SDA bits during REG then DATA read 00011010 then 10100101; SDA is stable whenever SCL is released, except at START and STOP.
REQ-029 Slave NACKs the address slot -> AckErr=1, STOP is issued immediately after ACK1, and WriteDone pulses at accept+(1+9+1)*16=176 clks with CLK_DIV=4.
REQ-030 Second WrReq with WrData=16'h1C10 asserted mid-frame -> ignored; a single WriteDone; the bus still carries the first word.
REQ-031 rst pulled low during REG bit 3 -> scl_oe=sda_oe=0 in the same cycle, Busy=0, no WriteDone; after release, a new request completes normally.
REQ-032 Five back-to-back requests, each issued the cycle after WriteDone -> five frames and five WriteDone pulses; Busy low for exactly one clk between frames.
